// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per channel a 2-flop synchroniser, a stability counter and a
// four-state FSM producing a clean level, one-cycle rise/fall pulses and optional auto-repeat.
module debounce_bank #(
    parameter int   CH            = 4,
    parameter int   STABLE_CYCLES = 1000000,
    parameter logic RST_LEVEL     = 1'b0,
    parameter int   REPEAT_EN     = 0,
    parameter int   REPEAT_DELAY  = 25000000,
    parameter int   REPEAT_PERIOD = 5000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] i,
    output logic [CH-1:0] o_level,
    output logic [CH-1:0] o_rise,
    output logic [CH-1:0] o_fall,
    output logic [CH-1:0] o_rpt
);

    localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_LO,
        CHK_HI,
        IDLE_HI,
        CHK_LO
    } state_t;

    localparam state_t RST_STATE = RST_LEVEL ? IDLE_HI : IDLE_LO;

    genvar k;
    generate
        for (k = 0; k < CH; k++) begin : g_ch
            logic             r_sync1;
            logic             r_sync2;
            state_t           r_state;
            state_t           w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic             r_level;
            logic             w_level_nxt;
            logic             r_rise;
            logic             w_rise_nxt;
            logic             r_fall;
            logic             w_fall_nxt;
            logic             w_mismatch;

            // NOTE: every flop is written with <= so all of them sample pre-edge values;
            // a blocking '=' here would collapse the two synchroniser stages into one.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync1 <= RST_LEVEL;
                    r_sync2 <= RST_LEVEL;
                end else begin
                    r_sync1 <= i[k];
                    r_sync2 <= r_sync1;
                end
            end

            assign w_mismatch = (r_sync2 != r_level);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_state <= RST_STATE;
                    r_cnt   <= '0;
                    r_level <= RST_LEVEL;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_level <= w_level_nxt;
                    r_rise  <= w_rise_nxt;
                    r_fall  <= w_fall_nxt;
                end
            end

            // r_cnt holds the number of consecutive mismatching samples already seen,
            // so leaving IDLE on the first mismatch starts the count at one.
            always_comb begin
                // NOTE: defaults first so every path assigns every signal and no latch is inferred.
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_level_nxt = r_level;
                w_rise_nxt  = 1'b0;
                w_fall_nxt  = 1'b0;
                case (r_state)
                    IDLE_LO: begin
                        w_cnt_nxt = '0;
                        if (w_mismatch) begin
                            if (STABLE_CYCLES == 1) begin
                                w_state_nxt = IDLE_HI;
                                w_level_nxt = 1'b1;
                                w_rise_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = CHK_HI;
                                w_cnt_nxt   = CNT_ONE;
                            end
                        end
                    end
                    CHK_HI: begin
                        if (!w_mismatch) begin
                            w_state_nxt = IDLE_LO;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == STABLE_LAST) begin
                            w_state_nxt = IDLE_HI;
                            w_cnt_nxt   = '0;
                            w_level_nxt = 1'b1;
                            w_rise_nxt  = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end
                    IDLE_HI: begin
                        w_cnt_nxt = '0;
                        if (w_mismatch) begin
                            if (STABLE_CYCLES == 1) begin
                                w_state_nxt = IDLE_LO;
                                w_level_nxt = 1'b0;
                                w_fall_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = CHK_LO;
                                w_cnt_nxt   = CNT_ONE;
                            end
                        end
                    end
                    CHK_LO: begin
                        if (!w_mismatch) begin
                            w_state_nxt = IDLE_HI;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == STABLE_LAST) begin
                            w_state_nxt = IDLE_LO;
                            w_cnt_nxt   = '0;
                            w_level_nxt = 1'b0;
                            w_fall_nxt  = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt = RST_STATE;
                        w_cnt_nxt   = '0;
                        w_level_nxt = RST_LEVEL;
                    end
                endcase
            end

            assign o_level[k] = r_level;
            assign o_rise[k]  = r_rise;
            assign o_fall[k]  = r_fall;

            if (REPEAT_EN != 0) begin : g_rpt
                localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY);
                localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_PERIOD);
                localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

                logic [RPT_W-1:0] r_rpt_cnt;
                logic             r_armed;
                logic             r_rpt;
                logic [RPT_W-1:0] w_rpt_lim;
                logic [RPT_W-1:0] w_rpt_inc;

                // The count restarts after each pulse; r_armed selects the first-delay or period limit.
                assign w_rpt_lim = r_armed ? RPT_PER : RPT_DLY;
                assign w_rpt_inc = r_rpt_cnt + RPT_ONE;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_rpt_cnt <= '0;
                        r_armed   <= 1'b0;
                        r_rpt     <= 1'b0;
                    end else if (!r_level || w_fall_nxt) begin
                        r_rpt_cnt <= '0;
                        r_armed   <= 1'b0;
                        r_rpt     <= 1'b0;
                    end else if (w_rpt_inc == w_rpt_lim) begin
                        r_rpt_cnt <= '0;
                        r_armed   <= 1'b1;
                        r_rpt     <= 1'b1;
                    end else begin
                        r_rpt <= 1'b0;
                        if (r_rpt_cnt != '1) begin
                            r_rpt_cnt <= w_rpt_inc;
                        end
                    end
                end

                assign o_rpt[k] = r_rpt;
            end else begin : g_no_rpt
                assign o_rpt[k] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: expectations are queued with the cycle they are due and
// compared by immediate assertions as the clock reaches that cycle.
module tb_debounce_bank;

    logic       clk;
    logic       rst_n;
    logic [1:0] i;
    logic [1:0] o_level;
    logic [1:0] o_rise;
    logic [1:0] o_fall;
    logic [1:0] o_rpt;

    typedef struct {
        string      tag;
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    debounce_bank #(
        .CH           (2),
        .STABLE_CYCLES(4),
        .RST_LEVEL    (1'b0),
        .REPEAT_EN    (1),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i      (i),
        .o_level(o_level),
        .o_rise (o_rise),
        .o_fall (o_fall),
        .o_rpt  (o_rpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expectation value layout: {o_level, o_rise, o_fall, o_rpt}.
    task automatic push(input string tag, input int at, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.cyc = at;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t       e;
        logic [7:0] obs;
        @(posedge clk);
        cyc++;
        #1;
        obs = {o_level, o_rise, o_fall, o_rpt};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_check++;
            assert (obs === e.val && e.cyc == cyc) else begin
                n_fail++;
                $error("FAIL %s cyc=%0d due=%0d got=%b want=%b", e.tag, cyc, e.cyc, obs, e.val);
            end
        end
    endtask

    task automatic run_until(input int at);
        while (cyc < at) tick();
    endtask

    task automatic do_reset(input string tag);
        push(tag, cyc + 1, 8'h00);
        rst_n = 1'b0;
        i     = 2'b00;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        int r;

        // Reset held with both inputs high, then both channels accept together.
        rst_n = 1'b0;
        i     = 2'b11;
        push("rst_e1", 1, 8'h00);
        push("rst_e3", 3, 8'h00);
        run_until(3);
        rst_n = 1'b1;
        c = cyc;
        push("rel_pre",  c + 5,  8'b00_00_00_00);
        push("rel_acc",  c + 6,  8'b11_11_00_00);
        push("rel_hold", c + 7,  8'b11_00_00_00);
        push("rel_rpt",  c + 16, 8'b11_00_00_11);
        push("rel_rpt0", c + 17, 8'b11_00_00_00);
        run_until(c + 17);

        // Reset while high clears the level without a fall pulse.
        do_reset("rst_no_fall");

        // Channel 0 rise, auto-repeat train, then fall aligned with a due repeat.
        c = cyc;
        i = 2'b01;
        r = c + 6;
        push("ch0_pre",  c + 5,  8'b00_00_00_00);
        push("ch0_rise", r,      8'b01_01_00_00);
        push("ch0_hold", r + 1,  8'b01_00_00_00);
        push("rpt_pre",  r + 9,  8'b01_00_00_00);
        push("rpt_1",    r + 10, 8'b01_00_00_01);
        push("rpt_gap",  r + 11, 8'b01_00_00_00);
        push("rpt_2",    r + 13, 8'b01_00_00_01);
        push("rpt_3",    r + 16, 8'b01_00_00_01);
        push("rpt_gap2", r + 18, 8'b01_00_00_00);
        push("rpt_4",    r + 19, 8'b01_00_00_01);
        run_until(r + 22);
        i = 2'b00;
        push("rpt_5",    r + 25, 8'b01_00_00_01);
        push("fall",     r + 28, 8'b00_00_01_00);
        push("fall_end", r + 29, 8'b00_00_00_00);
        push("no_rpt",   r + 31, 8'b00_00_00_00);
        run_until(r + 31);

        // One-cycle glitch restarts the stability count.
        do_reset("rst_glitch");
        c = cyc;
        i = 2'b01;
        run_until(c + 3);
        i = 2'b00;
        run_until(c + 4);
        i = 2'b01;
        push("gl_early", c + 6,  8'b00_00_00_00);
        push("gl_pre",   c + 9,  8'b00_00_00_00);
        push("gl_rise",  c + 10, 8'b01_01_00_00);
        push("gl_hold",  c + 11, 8'b01_00_00_00);
        run_until(c + 11);

        // Reset in CHK_HI at cnt=3 discards progress; a full count is needed again.
        do_reset("rst_t5");
        c = cyc;
        i = 2'b01;
        push("t5_cnt3", c + 5, 8'b00_00_00_00);
        run_until(c + 5);
        rst_n = 1'b0;
        push("t5_rst", c + 6, 8'b00_00_00_00);
        tick();
        rst_n = 1'b1;
        push("t5_wait", c + 8,  8'b00_00_00_00);
        push("t5_pre",  c + 11, 8'b00_00_00_00);
        push("t5_rise", c + 12, 8'b01_01_00_00);
        run_until(c + 12);

        // Channel 1 chatters every 2 cycles while channel 0 rises and repeats.
        do_reset("rst_t6");
        c = cyc;
        push("t6_rise",  c + 6,  8'b01_01_00_00);
        push("t6_hold",  c + 7,  8'b01_00_00_00);
        push("t6_rpt1",  c + 16, 8'b01_00_00_01);
        push("t6_mid",   c + 30, 8'b01_00_00_00);
        push("t6_rpt12", c + 49, 8'b01_00_00_01);
        push("t6_end",   c + 50, 8'b01_00_00_00);
        for (int t = 0; t < 50; t++) begin
            i = {~t[1], 1'b1};
            tick();
        end

        n_check++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain pending=%0d want=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "timeout");
    end

endmodule
